amba_apb_slave_mem: RTL

Parametrised APB4 memory-mapped slave; successor to the fixed 8-bit/64-entry APB slave. Adds configurable data width, depth and wait states, byte-strobe writes, and PSLVERR on out-of-range access. It sits behind the APB interconnect as a generic scratch/register RAM and serves as the bench target for APB master verification.

---
 rtl/amba_apb_pkg.sv | 20 ++
 rtl/amba_apb_mem_array.sv | 41 ++++
 rtl/amba_apb_slave_mem.sv | 110 +++++++++++
 3 files changed

// File: rtl/amba_apb_pkg.sv
// Shared types and elaboration helpers for the parametrised APB4 memory slave.
package amba_apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned CNT_W           = 4;

  function automatic int unsigned align_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/amba_apb_mem_array.sv
// DEPTH x DATA_W word RAM with per-byte write enables and a registered read port.
module amba_apb_mem_array
  import amba_apb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned AW     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic                  rzero,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned STRB_W = strb_width(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (we[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register only reloads on a read setup; it holds across writes and idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/amba_apb_slave_mem.sv
// APB4 memory-mapped slave: configurable width/depth/wait states, byte strobes, PSLVERR on out-of-range.
module amba_apb_slave_mem
  import amba_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr
);

  localparam int unsigned ALIGN  = align_bits(DATA_W);
  localparam int unsigned STRB_W = strb_width(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - ALIGN;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]     DEPTH_L   = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   WAIT_INIT = CNT_W'(WAIT_STATES);

  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("amba_apb_slave_mem: DATA_W must be 8, 16 or 32");
  end
  if (WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
    $error("amba_apb_slave_mem: WAIT_STATES out of range 0..15");
  end
  if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << IDX_W)) begin : g_bad_depth
    $error("amba_apb_slave_mem: DEPTH must be 1..2**(ADDR_W-ALIGN)");
  end

  apb_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [IDX_W-1:0]   idx;
  logic [AW-1:0]      word_addr;
  logic               in_range;
  logic               setup;
  logic               complete;
  logic               rd_load;
  logic [STRB_W-1:0]  we;

  assign idx       = paddr[ADDR_W-1:ALIGN];
  assign word_addr = idx[AW-1:0];
  assign in_range  = ({1'b0, idx} < DEPTH_L);

  if (ALIGN > 0) begin : g_unused_low
    logic unused_low;
    assign unused_low = ^paddr[ALIGN-1:0];
  end

  assign setup    = (state == IDLE) && psel && !penable;
  assign pready   = (state == ACCESS) && (cnt == '0);
  assign pslverr  = pready && err_q;
  assign complete = pready && psel && penable;
  assign rd_load  = setup && !pwrite;
  assign we       = (complete && pwrite && in_range) ? pstrb : '0;

  // Abort (psel low) takes priority over any wait-state progress.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            cnt   <= WAIT_INIT;
            err_q <= !in_range;
          end
        end
        ACCESS: begin
          if (!psel || complete) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  amba_apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (pclk),
    .rst_n (preset),
    .we    (we),
    .waddr (word_addr),
    .wdata (pwdata),
    .re    (rd_load),
    .rzero (!in_range),
    .raddr (word_addr),
    .rdata (prdata)
  );

endmodule
